// File: rtl/acc_seq_pkg.sv
// Shared opcodes, FSM state encoding and the strobe bundle for the accumulator sequencer.
package acc_seq_pkg;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDA = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_MAC = 3'd4;
  localparam logic [2:0] OP_OUT = 3'd5;
  localparam logic [2:0] OP_CLR = 3'd6;
  localparam logic [2:0] OP_HLT = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADA,
    S_LOADB,
    S_EXEC,
    S_OUT,
    S_HALT
  } state_t;

  // Registered control strobes presented to the datapath and the host.
  typedef struct packed {
    logic drv_en;
    logic nla;
    logic nlb;
    logic ea;
    logic eu;
    logic sub;
    logic out_valid;
    logic done;
    logic halted;
  } strobes_t;

  // All loads inactive (active-low), nothing driving the bus.
  localparam strobes_t STROBES_IDLE = '{
    drv_en:    1'b0,
    nla:       1'b1,
    nlb:       1'b1,
    ea:        1'b0,
    eu:        1'b0,
    sub:       1'b0,
    out_valid: 1'b0,
    done:      1'b0,
    halted:    1'b0
  };

endpackage

// File: rtl/acc_sequencer.sv
// Command-driven sequencer for the accumulator / B-register / ALU datapath.
// One command at a time over valid/ready; strobes are registered so that
// every output depends only on flops, never combinationally on cmd_*.
module acc_sequencer
  import acc_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic [WIDTH-1:0] bus_drv,
  output logic             bus_drv_en,
  output logic             nLa,
  output logic             nLb,
  output logic             Ea,
  output logic             Eu,
  output logic             sub,
  input  logic             cf_in,
  input  logic             zf_in,
  output logic             flag_c,
  output logic             flag_z,
  output logic             out_valid,
  output logic             done,
  output logic             halted
);

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] rem_q, rem_d;
  strobes_t         strobes_q, strobes_d;
  logic [WIDTH-1:0] bus_q, bus_d;
  logic             accept;
  logic [2:0]       eff_op;
  logic [WIDTH-1:0] eff_data;
  logic [CNT_W-1:0] eff_cnt;

  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  // The command steering the next cycle: the one being accepted, else the latched one.
  assign eff_op   = accept ? cmd_op   : op_q;
  assign eff_data = accept ? cmd_data : data_q;
  assign eff_cnt  = accept ? cmd_cnt  : cnt_q;

  // Next-state, repeat-counter and next-cycle strobe decode.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    strobes_d = STROBES_IDLE;
    bus_d     = '0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_LDA, OP_CLR:         state_d = S_LOADA;
            OP_ADD, OP_SUB, OP_MAC: state_d = S_LOADB;
            OP_OUT:                 state_d = S_OUT;
            OP_HLT:                 state_d = S_HALT;
            default:                state_d = S_IDLE;
          endcase
        end
      end
      S_LOADB: begin
        if (op_q == OP_MAC && cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_EXEC;
          rem_d   = (op_q == OP_MAC) ? cnt_q : CNT_W'(1);
        end
      end
      S_EXEC: begin
        if (rem_q > CNT_W'(1)) begin
          rem_d = rem_q - CNT_W'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_LOADA: begin
        strobes_d.drv_en = 1'b1;
        strobes_d.nla    = 1'b0;
        strobes_d.done   = 1'b1;
        bus_d            = (eff_op == OP_CLR) ? '0 : eff_data;
      end
      S_LOADB: begin
        strobes_d.drv_en = 1'b1;
        strobes_d.nlb    = 1'b0;
        strobes_d.done   = (eff_op == OP_MAC) && (eff_cnt == '0);
        bus_d            = eff_data;
      end
      S_EXEC: begin
        strobes_d.eu   = 1'b1;
        strobes_d.nla  = 1'b0;
        strobes_d.sub  = (op_q == OP_SUB);
        strobes_d.done = (rem_d == CNT_W'(1));
      end
      S_OUT: begin
        strobes_d.ea        = 1'b1;
        strobes_d.out_valid = 1'b1;
        strobes_d.done      = 1'b1;
      end
      S_HALT: strobes_d.halted = 1'b1;
      default: strobes_d.done = (state_q == S_IDLE) && accept && (cmd_op == OP_NOP);
    endcase
  end

  // Command latch; only meaningful after an accept, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= cmd_op;
      data_q <= cmd_data;
      cnt_q  <= cmd_cnt;
    end
  end

  // FSM state, repeat counter, registered strobes and ALU flag capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      strobes_q <= STROBES_IDLE;
      bus_q     <= '0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      strobes_q <= strobes_d;
      bus_q     <= bus_d;
      if (state_q == S_EXEC) begin
        flag_c <= cf_in;
        flag_z <= zf_in;
      end
    end
  end

  assign bus_drv    = bus_q;
  assign bus_drv_en = strobes_q.drv_en;
  assign nLa        = strobes_q.nla;
  assign nLb        = strobes_q.nlb;
  assign Ea         = strobes_q.ea;
  assign Eu         = strobes_q.eu;
  assign sub        = strobes_q.sub;
  assign out_valid  = strobes_q.out_valid;
  assign done       = strobes_q.done;
  assign halted     = strobes_q.halted;

endmodule

// File: tb/tb_acc_sequencer.sv
// Bench for acc_sequencer: a datapath environment (A, B, ALU) driven by the
// strobes, a command-level predictor of every output cycle, and directed tests.
module tb_acc_sequencer;
  import acc_seq_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic [2:0]       cmd_op = 3'd0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [CNT_W-1:0] cmd_cnt = '0;
  logic             cmd_ready;
  logic [WIDTH-1:0] bus_drv;
  logic             bus_drv_en, nLa, nLb, Ea, Eu, sub;
  logic             cf_in, zf_in, flag_c, flag_z, out_valid, done, halted;

  int n_chk = 0;
  int n_fail = 0;

  acc_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt),
    .bus_drv(bus_drv), .bus_drv_en(bus_drv_en),
    .nLa(nLa), .nLb(nLb), .Ea(Ea), .Eu(Eu), .sub(sub),
    .cf_in(cf_in), .zf_in(zf_in), .flag_c(flag_c), .flag_z(flag_z),
    .out_valid(out_valid), .done(done), .halted(halted)
  );

  always #5 clk = ~clk;

  // Datapath environment: A and B registers on a shared bus, ALU feeding the flags.
  logic [7:0] dp_a = 8'h00;
  logic [7:0] dp_b = 8'h00;
  logic [7:0] dp_bus;
  logic [8:0] alu;

  always_comb begin
    alu = sub ? ({1'b0, dp_a} + {1'b0, ~dp_b} + 9'd1) : ({1'b0, dp_a} + {1'b0, dp_b});
    dp_bus = 8'h00;
    if (bus_drv_en)  dp_bus = bus_drv;
    else if (Eu)     dp_bus = alu[7:0];
    else if (Ea)     dp_bus = dp_a;
  end
  assign cf_in = alu[8];
  assign zf_in = (alu[7:0] == 8'h00);

  always @(posedge clk) begin
    if (!nLa) dp_a <= dp_bus;
    if (!nLb) dp_b <= dp_bus;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Expected content of one output cycle, produced from command semantics.
  typedef struct packed {
    logic [7:0] bus;
    logic drv_en, nla, nlb, ea, eu, sb, ov, dn, rdy;
    logic upd, fc, fz;
    logic [7:0] acc;
  } exp_t;

  exp_t       q[$];
  logic [7:0] acc_tail = 8'h00;
  logic [7:0] acc_cur = 8'h00;
  logic       fc_exp = 1'b0;
  logic       fz_exp = 1'b0;
  logic       halt_exp = 1'b0;

  function automatic exp_t blank(input logic [7:0] a);
    exp_t e;
    e = '0;
    e.nla = 1'b1;
    e.nlb = 1'b1;
    e.acc = a;
    return e;
  endfunction

  function automatic logic [17:0] expv(input exp_t e, input logic h);
    return {e.bus, e.drv_en, e.nla, e.nlb, e.ea, e.eu, e.sb, e.ov, e.dn, e.rdy, h};
  endfunction

  task automatic push_cmd(input logic [2:0] op, input logic [7:0] d, input logic [3:0] n);
    exp_t e;
    logic [8:0] r;
    case (op)
      OP_NOP: begin
        e = blank(acc_tail); e.rdy = 1'b1; e.dn = 1'b1; q.push_back(e);
      end
      OP_LDA, OP_CLR: begin
        e = blank((op == OP_LDA) ? d : 8'h00);
        e.drv_en = 1'b1; e.bus = e.acc; e.nla = 1'b0; e.dn = 1'b1;
        q.push_back(e); acc_tail = e.acc;
      end
      OP_ADD, OP_SUB: begin
        e = blank(acc_tail); e.drv_en = 1'b1; e.bus = d; e.nlb = 1'b0; q.push_back(e);
        if (op == OP_ADD) r = 9'(acc_tail) + 9'(d);
        else              r = {acc_tail >= d, acc_tail - d};
        e = blank(r[7:0]); e.eu = 1'b1; e.nla = 1'b0; e.sb = (op == OP_SUB); e.dn = 1'b1;
        e.upd = 1'b1; e.fc = r[8]; e.fz = (r[7:0] == 8'h00);
        q.push_back(e); acc_tail = r[7:0];
      end
      OP_MAC: begin
        e = blank(acc_tail); e.drv_en = 1'b1; e.bus = d; e.nlb = 1'b0; e.dn = (n == 4'd0);
        q.push_back(e);
        for (int i = 0; i < int'(n); i++) begin
          r = 9'(acc_tail) + 9'(d);
          e = blank(r[7:0]); e.eu = 1'b1; e.nla = 1'b0; e.dn = (i == int'(n) - 1);
          e.upd = 1'b1; e.fc = r[8]; e.fz = (r[7:0] == 8'h00);
          q.push_back(e); acc_tail = r[7:0];
        end
      end
      OP_OUT: begin
        e = blank(acc_tail); e.ea = 1'b1; e.ov = 1'b1; e.dn = 1'b1; q.push_back(e);
      end
      default: halt_exp = 1'b1;
    endcase
  endtask

  // Per-cycle comparison of every DUT output against the predicted cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      check("acc_value", 32'(dp_a), 32'(acc_cur));
      check("strobe_excl", 32'(((int'(bus_drv_en) + int'(Ea) + int'(Eu)) <= 1) && !(!nLa && !nLb)), 32'd1);
      if (rst) begin
        check("reset_outs", 32'({bus_drv, bus_drv_en, nLa, nLb, Ea, Eu, sub, out_valid, done, cmd_ready, halted}),
              32'(expv(blank(acc_cur), 1'b0)));
        check("reset_flags", 32'({flag_c, flag_z}), 32'd0);
        q.delete();
        fc_exp = 1'b0; fz_exp = 1'b0; halt_exp = 1'b0;
        acc_tail = acc_cur;
      end else begin
        if (q.size() > 0) e = q.pop_front();
        else begin e = blank(acc_cur); e.rdy = !halt_exp; end
        check("cycle_outs", 32'({bus_drv, bus_drv_en, nLa, nLb, Ea, Eu, sub, out_valid, done, cmd_ready, halted}),
              32'(expv(e, halt_exp)));
        check("cycle_flags", 32'({flag_c, flag_z}), 32'({fc_exp, fz_exp}));
        if (e.ov) check("out_bus", 32'(dp_bus), 32'(acc_cur));
        if (e.upd) begin fc_exp = e.fc; fz_exp = e.fz; end
        acc_cur = e.acc;
        if (e.rdy && cmd_valid) push_cmd(cmd_op, cmd_data, cmd_cnt);
      end
    end
  end

  task automatic run_cmd(input string nm, input logic [2:0] op, input logic [7:0] d,
                         input logic [3:0] n, input int exp_lat);
    int lat;
    bit ok;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_cnt = n; ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    check({nm, "_accept"}, 32'(ok), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (exp_lat > 0) begin
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk);
        if (done) begin lat = i; break; end
      end
      check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    end
  endtask

  logic [2:0] b_op  [8] = '{OP_LDA, OP_ADD, OP_NOP, OP_SUB, OP_MAC, OP_OUT, OP_CLR, OP_OUT};
  logic [7:0] b_dat [8] = '{8'h10, 8'h01, 8'h00, 8'h02, 8'h03, 8'h00, 8'h5A, 8'h00};
  logic [3:0] b_cnt [8] = '{4'd0, 4'd5, 4'd0, 4'd0, 4'd2, 4'd0, 4'd0, 4'd0};

  initial begin
    int idx;
    bit ok;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_nla", 32'(nLa), 32'd1);
    check("rst_halted", 32'(halted), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(cmd_ready), 32'd1);

    // LDA 5, ADD 3, OUT: accumulator presents 0x08.
    run_cmd("lda5", OP_LDA, 8'h05, 4'd0, 1);
    run_cmd("add3", OP_ADD, 8'h03, 4'd0, 2);
    run_cmd("out8", OP_OUT, 8'h00, 4'd0, 1);
    check("out8_value", 32'(dp_bus), 32'h08);
    check("out8_valid", 32'(out_valid), 32'd1);
    check("out8_flag_z", 32'(flag_z), 32'd0);
    @(negedge clk);
    check("out8_valid_drop", 32'(out_valid), 32'd0);

    // LDA 2, SUB 2: zero result, subtract only during EXEC.
    run_cmd("lda2", OP_LDA, 8'h02, 4'd0, 1);
    check("lda2_sub_low", 32'(sub), 32'd0);
    run_cmd("sub2", OP_SUB, 8'h02, 4'd0, 2);
    check("sub2_sub_exec", 32'(sub), 32'd1);
    @(negedge clk);
    check("sub2_acc", 32'(dp_a), 32'h00);
    check("sub2_flag_z", 32'(flag_z), 32'd1);
    check("sub2_sub_drop", 32'(sub), 32'd0);

    // LDA FF, ADD 1: wrap to zero with carry.
    run_cmd("ldaff", OP_LDA, 8'hFF, 4'd0, 1);
    run_cmd("add1", OP_ADD, 8'h01, 4'd0, 2);
    @(negedge clk);
    check("wrap_acc", 32'(dp_a), 32'h00);
    check("wrap_flags", 32'({flag_c, flag_z}), 32'b11);

    // LDA 0, MAC 7 x3 -> 0x15; MAC x0 leaves A alone.
    run_cmd("lda0", OP_LDA, 8'h00, 4'd0, 1);
    run_cmd("mac3", OP_MAC, 8'h07, 4'd3, 4);
    @(negedge clk);
    check("mac3_acc", 32'(dp_a), 32'h15);
    run_cmd("mac0", OP_MAC, 8'h09, 4'd0, 1);
    check("mac0_in_loadb", 32'(nLb), 32'd0);
    @(negedge clk);
    check("mac0_acc", 32'(dp_a), 32'h15);
    run_cmd("nop", OP_NOP, 8'h00, 4'd0, 1);

    // Back-to-back commands with cmd_valid held high.
    @(posedge clk); #1;
    idx = 0;
    cmd_valid = 1'b1; cmd_op = b_op[0]; cmd_data = b_dat[0]; cmd_cnt = b_cnt[0];
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk); #1;
        idx++;
        if (idx == 8) begin cmd_valid = 1'b0; break; end
        cmd_op = b_op[idx]; cmd_data = b_dat[idx]; cmd_cnt = b_cnt[idx];
      end
    end
    check("b2b_accepted", 32'(idx), 32'd8);
    repeat (6) @(negedge clk);
    check("b2b_acc", 32'(dp_a), 32'h00);

    // Reset mid-MAC (0x80 x5) after two EXEC cycles: carry and zero were set.
    run_cmd("ldz", OP_LDA, 8'h00, 4'd0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = OP_MAC; cmd_data = 8'h80; cmd_cnt = 4'd5; ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    check("abort_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_in_exec", 32'(Eu), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_async", 32'({bus_drv_en, Ea, Eu, nLa, nLb, done, flag_c, flag_z, cmd_ready}), 32'b000110000);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    check("abort_flags", 32'({flag_c, flag_z}), 32'd0);

    // HLT holds off commands until reset.
    run_cmd("hlt", OP_HLT, 8'h00, 4'd0, 0);
    cmd_valid = 1'b1; cmd_op = OP_LDA; cmd_data = 8'h44;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("halt_hold", 32'({halted, cmd_ready}), 32'b10);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("halt_cleared", 32'({halted, cmd_ready}), 32'b01);
    run_cmd("lda33", OP_LDA, 8'h33, 4'd0, 1);
    @(negedge clk);
    check("lda33_acc", 32'(dp_a), 32'h33);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
